// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with input synchroniser, false-start rejection,
// optional parity and 1 or 2 stop bits; one rx_done pulse per received frame.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 b_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                 par_acc, par_acc_n;
  logic                 perr_acc, perr_acc_n;
  logic                 ferr_acc, ferr_acc_n;
  logic                 done_n, perr_n, ferr_n;
  logic                 centre;

  assign rx_s   = sync[1];
  assign centre = b_tick && (tick_cnt == TICK_LAST);
  assign busy   = (state == DATA) || (state == PAR) || (state == STOP) || (state == BRK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= 2'b11;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_done    <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sync       <= {sync[0], rx};
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      par_acc    <= par_acc_n;
      perr_acc   <= perr_acc_n;
      ferr_acc   <= ferr_acc_n;
      rx_done    <= done_n;
      rx_data    <= data_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    par_acc_n  = par_acc;
    perr_acc_n = perr_acc;
    ferr_acc_n = ferr_acc;
    done_n     = 1'b0;
    data_n     = rx_data;
    perr_n     = parity_err;
    ferr_n     = frame_err;
    case (state)
      IDLE: begin
        if (b_tick && !rx_s) begin
          tick_n     = '0;
          bit_n      = '0;
          par_acc_n  = 1'b0;
          perr_acc_n = 1'b0;
          ferr_acc_n = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        // Re-check the line half a bit in so short glitches never start a frame
        if (b_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              tick_n  = '0;
              state_n = DATA;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (centre) begin
          tick_n    = '0;
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          par_acc_n = par_acc ^ rx_s;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else if (b_tick) begin
          tick_n = tick_cnt + 1'b1;
        end
      end
      PAR: begin
        if (centre) begin
          tick_n     = '0;
          perr_acc_n = (PARITY == 1) ? !(par_acc ^ rx_s) : (par_acc ^ rx_s);
          state_n    = STOP;
        end else if (b_tick) begin
          tick_n = tick_cnt + 1'b1;
        end
      end
      STOP: begin
        if (centre) begin
          tick_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            done_n  = 1'b1;
            data_n  = shreg;
            perr_n  = perr_acc;
            ferr_n  = ferr_acc | !rx_s;
            state_n = (ferr_acc || !rx_s) ? BRK : IDLE;
          end else begin
            bit_n      = bit_cnt + 1'b1;
            ferr_acc_n = ferr_acc | !rx_s;
          end
        end else if (b_tick) begin
          tick_n = tick_cnt + 1'b1;
        end
      end
      BRK: begin
        // A held-low line must return high before another frame can start
        if (b_tick && rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four parameter sets, directed scenarios plus
// randomized frames scored against a frame-level reference model.
module tb_uart_rx_cfg;

  logic       clk;
  logic       rst;
  logic       b_tick;
  logic [3:0] rx_line;
  logic [3:0] done, pe, fe, busy;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic [8:0] data3;

  int tests = 0;
  int fails = 0;

  // {source, frame_err, parity_err, data[8:0]}
  logic [12:0] got[$];
  logic [12:0] expq[$];

  int cfg_db[4]  = '{8, 8, 7, 9};
  int cfg_par[4] = '{0, 2, 0, 1};
  int cfg_sb[4]  = '{1, 1, 2, 1};
  int cfg_os[4]  = '{16, 16, 16, 8};

  uart_rx_cfg u_dut0 (.clk(clk), .rst(rst), .rx(rx_line[0]), .b_tick(b_tick), .rx_data(data0),
                      .rx_done(done[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(busy[0]));
  uart_rx_cfg #(.DATA_BITS(8), .PARITY(2)) u_dut1 (.clk(clk), .rst(rst), .rx(rx_line[1]), .b_tick(b_tick),
                      .rx_data(data1), .rx_done(done[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(busy[1]));
  uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .rx(rx_line[2]), .b_tick(b_tick),
                      .rx_data(data2), .rx_done(done[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(busy[2]));
  uart_rx_cfg #(.DATA_BITS(9), .PARITY(1), .OVERSAMPLE(8)) u_dut3 (.clk(clk), .rst(rst), .rx(rx_line[3]),
                      .b_tick(b_tick), .rx_data(data3), .rx_done(done[3]), .parity_err(pe[3]), .frame_err(fe[3]),
                      .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    b_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done[0]) got.push_back({2'd0, fe[0], pe[0], 1'b0, data0});
    if (done[1]) got.push_back({2'd1, fe[1], pe[1], 1'b0, data1});
    if (done[2]) got.push_back({2'd2, fe[2], pe[2], 2'b00, data2});
    if (done[3]) got.push_back({2'd3, fe[3], pe[3], data3});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (b_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic sendBit(input int idx, input logic v);
    rx_line[idx] = v;
    waitTicks(cfg_os[idx]);
  endtask

  // Drives one frame and records what the receiver must report for it
  task automatic applyStimulus(input int idx, input logic [8:0] data, input bit flip,
                               input logic [1:0] stop_low, input int gap);
    logic [8:0] d;
    logic       pbit;
    logic       exp_pe, exp_fe;
    d      = data & ((9'h1 << cfg_db[idx]) - 9'h1);
    pbit   = 1'b0;
    exp_pe = 1'b0;
    exp_fe = 1'b0;
    sendBit(idx, 1'b0);
    for (int i = 0; i < cfg_db[idx]; i++) sendBit(idx, d[i]);
    if (cfg_par[idx] != 0) begin
      pbit = (^d) ^ (cfg_par[idx] == 1) ^ flip;
      sendBit(idx, pbit);
      exp_pe = ((^d) ^ pbit) != (cfg_par[idx] == 1);
    end
    for (int s = 0; s < cfg_sb[idx]; s++) begin
      sendBit(idx, !stop_low[s]);
      exp_fe = exp_fe | stop_low[s];
    end
    repeat (gap) sendBit(idx, 1'b1);
    expq.push_back({2'(idx), exp_fe, exp_pe, d});
  endtask

  task automatic checkFrames(input string tag);
    int n;
    logic [12:0] e, g;
    n = 0;
    while (got.size() < expq.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_count"}, got.size(), expq.size());
    while (expq.size() > 0 && got.size() > 0) begin
      e = expq.pop_front();
      g = got.pop_front();
      checkOutput({tag, "_src"}, g[12:11], e[12:11]);
      checkOutput({tag, "_data"}, g[8:0], e[8:0]);
      checkOutput({tag, "_perr"}, g[9], e[9]);
      checkOutput({tag, "_ferr"}, g[10], e[10]);
    end
    expq.delete();
    got.delete();
  endtask

  initial begin
    logic [1:0] sl;
    rx_line = 4'hF;
    rst     = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_data", data0, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_perr", pe, 0);
    checkOutput("rst_ferr", fe, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    waitTicks(20);

    applyStimulus(0, 9'hA5, 1'b0, 2'b00, 1);
    checkFrames("8n1_a5");

    applyStimulus(1, 9'h03, 1'b0, 2'b00, 1);
    applyStimulus(1, 9'h03, 1'b1, 2'b00, 1);
    checkFrames("even_par");

    rx_line[0] = 1'b0;
    waitTicks(4);
    rx_line[0] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waitTicks(1);
      checkOutput("glitch_busy", busy[0], 0);
    end
    checkFrames("glitch");

    applyStimulus(0, 9'h00, 1'b0, 2'b01, 0);
    waitTicks(16);
    checkOutput("break_busy", busy[0], 1);
    waitTicks(32);
    checkFrames("break");
    rx_line[0] = 1'b1;
    waitTicks(32);
    checkOutput("break_release_busy", busy[0], 0);
    applyStimulus(0, 9'h5A, 1'b0, 2'b00, 1);
    checkFrames("after_break");

    applyStimulus(2, 9'h41, 1'b0, 2'b00, 0);
    applyStimulus(2, 9'h7F, 1'b0, 2'b00, 1);
    checkFrames("b2b_7n2");
    applyStimulus(2, 9'h2B, 1'b0, 2'b10, 2);
    checkFrames("stop2_low");

    rx_line[0] = 1'b0;
    waitTicks(16);
    for (int i = 0; i < 3; i++) sendBit(0, (8'h3C >> i) & 8'h1);
    waitTicks(4);
    @(negedge clk);
    checkOutput("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_data", data0, 0);
    checkOutput("mid_rst_done", done[0], 0);
    checkOutput("mid_rst_flags", {pe[0], fe[0]}, 0);
    checkOutput("mid_rst_busy", busy[0], 0);
    rx_line[0] = 1'b1;
    waitTicks(48);
    checkFrames("rst_abort");
    applyStimulus(0, 9'h3C, 1'b0, 2'b00, 1);
    checkFrames("after_rst");

    for (int idx = 0; idx < 4; idx++) begin
      for (int k = 0; k < 5; k++) begin
        sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        applyStimulus(idx, 9'($urandom), (cfg_par[idx] != 0) && ($urandom_range(0, 2) == 0), sl,
                      (sl != 2'b00) ? 2 : int'($urandom_range(0, 1)));
      end
      rx_line[idx] = 1'b1;
      waitTicks(8);
      checkFrames("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
